// File: rtl/post_neuron_updater.sv
`default_nettype none
// ============================================================================
//  Module      : post_neuron_updater
//  Description : Read-modify-write sequencer for the post-neuron state SRAM.
//                Integrates signed synaptic events into membrane potentials
//                and, on a timestep-end request, sweeps every neuron to emit
//                spikes, reset fired membranes and bump a saturating counter.
//                Optional build macro POST_NEURON_LEAK_EN enables a
//                shift-based leak on non-spiking neurons during the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module post_neuron_updater #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int N_NEURON     = 256,
    parameter int MEM_WIDTH    = 16,
    parameter int CNT_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LEAK_SHIFT   = 4
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    evt_valid,
    output logic                    evt_ready,
    input  logic [ADDR_WIDTH-1:0]   evt_addr,
    input  logic [WEIGHT_WIDTH-1:0] evt_weight,
    input  logic                    tstep_start,
    input  logic [MEM_WIDTH-1:0]    threshold,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    spike_valid,
    input  logic                    spike_ready,
    output logic [ADDR_WIDTH-1:0]   spike_addr,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EV_RD   = 3'd1,
        S_EV_WR   = 3'd2,
        S_SW_RD   = 3'd3,
        S_SW_EVAL = 3'd4,
        S_SW_SPK  = 3'd5,
        S_SW_WR   = 3'd6,
        S_SW_DONE = 3'd7
    } state_t;

    localparam logic [MEM_WIDTH-1:0]  c_mem_max   = {1'b0, {(MEM_WIDTH-1){1'b1}}};
    localparam logic [MEM_WIDTH-1:0]  c_mem_min   = {1'b1, {(MEM_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max   = {CNT_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(N_NEURON - 1);

`ifdef POST_NEURON_LEAK_EN
    localparam bit c_leak_en = 1'b1;
`else
    localparam bit c_leak_en = 1'b0;
`endif

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_ev_addr;
    logic [WEIGHT_WIDTH-1:0]         r_ev_weight;
    logic [ADDR_WIDTH-1:0]           r_sw_addr;
    logic [DATA_WIDTH-1:0]           r_word;
    logic                            r_spiked;
    logic                            r_spike_valid;
    logic [ADDR_WIDTH-1:0]           r_spike_addr;
    logic                            r_sweep_done;

    logic signed [MEM_WIDTH-1:0]     w_q_mem;
    logic signed [MEM_WIDTH:0]       w_ev_sum;
    logic [MEM_WIDTH-1:0]            w_ev_mem;
    logic [DATA_WIDTH-1:0]           w_ev_word;
    logic signed [MEM_WIDTH-1:0]     w_sw_mem;
    logic [CNT_WIDTH-1:0]            w_sw_cnt;
    logic signed [MEM_WIDTH-1:0]     w_leak_mem;
    logic [DATA_WIDTH-1:0]           w_sw_word;

    assign w_q_mem  = sram_q[MEM_WIDTH-1:0];
    assign w_sw_mem = r_word[MEM_WIDTH-1:0];
    assign w_sw_cnt = r_word[MEM_WIDTH+CNT_WIDTH-1:MEM_WIDTH];

    // Event integrate: widen by one bit, add the sign-extended weight and clamp on overflow
    always_comb begin
        w_ev_sum = {w_q_mem[MEM_WIDTH-1], w_q_mem}
                 + {{(MEM_WIDTH+1-WEIGHT_WIDTH){r_ev_weight[WEIGHT_WIDTH-1]}}, r_ev_weight};
        if (w_ev_sum[MEM_WIDTH] != w_ev_sum[MEM_WIDTH-1]) begin
            w_ev_mem = w_ev_sum[MEM_WIDTH] ? c_mem_min : c_mem_max;
        end else begin
            w_ev_mem = w_ev_sum[MEM_WIDTH-1:0];
        end
        w_ev_word = sram_q;
        w_ev_word[MEM_WIDTH-1:0] = w_ev_mem;
    end

    // Sweep write-back word: fire resets membrane and bumps counter, otherwise hold (or leak)
    always_comb begin
        w_leak_mem = w_sw_mem - (w_sw_mem >>> LEAK_SHIFT);
        w_sw_word  = r_word;
        if (r_spiked) begin
            w_sw_word[MEM_WIDTH-1:0] = '0;
            w_sw_word[MEM_WIDTH+CNT_WIDTH-1:MEM_WIDTH] =
                (w_sw_cnt == c_cnt_max) ? w_sw_cnt : w_sw_cnt + CNT_WIDTH'(1);
        end else if (c_leak_en) begin
            w_sw_word[MEM_WIDTH-1:0] = w_leak_mem;
        end
    end

    // SRAM strobes decoded from state; reset gates them so an aborted op issues nothing
    always_comb begin
        sram_cs = 1'b0;
        sram_we = 1'b0;
        sram_a  = '0;
        sram_d  = '0;
        if (!RST) begin
            case (r_state)
                S_EV_RD: begin
                    sram_cs = 1'b1;
                    sram_a  = r_ev_addr;
                end
                S_EV_WR: begin
                    sram_cs = 1'b1;
                    sram_we = 1'b1;
                    sram_a  = r_ev_addr;
                    sram_d  = w_ev_word;
                end
                S_SW_RD: begin
                    sram_cs = 1'b1;
                    sram_a  = r_sw_addr;
                end
                S_SW_WR: begin
                    sram_cs = 1'b1;
                    sram_we = 1'b1;
                    sram_a  = r_sw_addr;
                    sram_d  = w_sw_word;
                end
                default: begin
                end
            endcase
        end
    end

    assign evt_ready   = (r_state == S_IDLE) && !tstep_start && !RST;
    assign busy        = (r_state != S_IDLE);
    assign sweep_done  = r_sweep_done;
    assign spike_valid = r_spike_valid;
    assign spike_addr  = r_spike_addr;

    // Main sequencer: event RMW and timestep sweep with spike handshake
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_ev_addr     <= '0;
            r_ev_weight   <= '0;
            r_sw_addr     <= '0;
            r_word        <= '0;
            r_spiked      <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_addr  <= '0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tstep_start) begin
                        r_sw_addr <= '0;
                        r_state   <= S_SW_RD;
                    end else if (evt_valid) begin
                        r_ev_addr   <= evt_addr;
                        r_ev_weight <= evt_weight;
                        r_state     <= S_EV_RD;
                    end
                end
                S_EV_RD: begin
                    r_state <= S_EV_WR;
                end
                S_EV_WR: begin
                    r_state <= S_IDLE;
                end
                S_SW_RD: begin
                    r_state <= S_SW_EVAL;
                end
                S_SW_EVAL: begin
                    r_word <= sram_q;
                    if (w_q_mem >= $signed(threshold)) begin
                        r_spiked      <= 1'b1;
                        r_spike_valid <= 1'b1;
                        r_spike_addr  <= r_sw_addr;
                        r_state       <= S_SW_SPK;
                    end else begin
                        r_spiked <= 1'b0;
                        r_state  <= S_SW_WR;
                    end
                end
                S_SW_SPK: begin
                    if (spike_ready) begin
                        r_spike_valid <= 1'b0;
                        r_state       <= S_SW_WR;
                    end
                end
                S_SW_WR: begin
                    if (r_sw_addr == c_last_addr) begin
                        r_sweep_done <= 1'b1;
                        r_state      <= S_SW_DONE;
                    end else begin
                        r_sw_addr <= r_sw_addr + ADDR_WIDTH'(1);
                        r_state   <= S_SW_RD;
                    end
                end
                S_SW_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_post_neuron_updater.sv
`default_nettype none
// ============================================================================
//  Module      : tb_post_neuron_updater
//  Description : Self-checking bench for post_neuron_updater with a behavioural
//                SRAM, directed vector table, corner sequences and randomized
//                events/sweeps against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_post_neuron_updater;

`ifdef POST_NEURON_LEAK_EN
    localparam bit c_leak = 1'b1;
`else
    localparam bit c_leak = 1'b0;
`endif

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [7:0]  evt_addr = '0;
    logic [7:0]  evt_weight = '0;
    logic        tstep_start = 1'b0;
    logic [15:0] threshold = '0;
    logic        busy, sweep_done, spike_valid;
    logic        spike_ready = 1'b0;
    logic [7:0]  spike_addr;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    logic [31:0] sram [256];
    logic [31:0] mdl  [256];
    logic        pl_en = 1'b0, pl_clr = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    int checks = 0;
    int errors = 0;
    int exp_spk[$];
    int got_spk[$];
    int ndone;

    post_neuron_updater dut (
        .CK(CK), .RST(RST),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_addr(evt_addr), .evt_weight(evt_weight),
        .tstep_start(tstep_start), .threshold(threshold),
        .busy(busy), .sweep_done(sweep_done),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 CK = ~CK;

    // Behavioural single-port SRAM with 1-cycle registered read plus bench preload path
    always @(posedge CK) begin
        if (pl_clr) begin
            for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
        end else if (pl_en) begin
            sram[pl_a] <= pl_d;
        end else if (sram_cs) begin
            if (sram_we) sram[sram_a] <= sram_d;
            else         sram_q <= sram[sram_a];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        pl_clr = 1'b1;
        @(negedge CK);
        pl_clr = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge CK);
        pl_en = 1'b0;
        mdl[a] = d;
    endtask

    function automatic logic [31:0] ev_model(input logic [31:0] w, input int wt);
        int m;
        m = int'($signed(w[15:0])) + wt;
        if (m > 32767)  m = 32767;
        if (m < -32768) m = -32768;
        return {w[31:16], m[15:0]};
    endfunction

    task automatic model_sweep(input logic [15:0] thr);
        int m, c;
        exp_spk.delete();
        for (int i = 0; i < 256; i++) begin
            m = int'($signed(mdl[i][15:0]));
            c = int'(mdl[i][23:16]);
            if (m >= int'($signed(thr))) begin
                m = 0;
                if (c < 255) c = c + 1;
                exp_spk.push_back(i);
            end else if (c_leak) begin
                m = m - (m >>> 4);
            end
            mdl[i] = {mdl[i][31:24], c[7:0], m[15:0]};
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where evt_ready is back
    task automatic do_event(input logic [7:0] a, input int wt, output int lat);
        int n = 0;
        evt_valid = 1'b1; evt_addr = a; evt_weight = wt[7:0];
        #1;
        while (!evt_ready && n < 20) begin @(negedge CK); #1; n++; end
        check("evt_accept", evt_ready, 1);
        @(posedge CK); #1;
        evt_valid = 1'b0;
        mdl[a] = ev_model(mdl[a], wt);
        lat = 1;
        @(negedge CK);
        while (!evt_ready && lat < 20) begin @(negedge CK); lat++; end
    endtask

    // Walks an in-progress sweep to completion, collecting spikes
    task automatic wait_sweep(input int bp, input bit rnd);
        int cyc = 0;
        int hold;
        bit done_seen = 0;
        logic [7:0] sa;
        ndone = 0;
        got_spk.delete();
        spike_ready = 1'b0;
        while (cyc < 4000) begin
            if (sweep_done) begin
                ndone++;
                done_seen = 1;
            end else if (done_seen) begin
                break;
            end
            if (spike_valid) begin
                sa = spike_addr;
                got_spk.push_back(int'(sa));
                hold = rnd ? int'($urandom_range(0, 3)) : bp;
                for (int k = 0; k < hold; k++) begin
                    @(negedge CK); cyc++;
                    check("spike_hold", {spike_valid, spike_addr}, {1'b1, sa});
                end
                spike_ready = 1'b1;
                @(negedge CK); cyc++;
                spike_ready = 1'b0;
            end else begin
                @(negedge CK); cyc++;
            end
        end
        check("sweep_timeout", cyc >= 4000, 0);
        check("sweep_done_pulses", ndone, 1);
        check("busy_after_sweep", busy, 0);
    endtask

    task automatic run_sweep(input logic [15:0] thr, input int bp, input bit rnd);
        threshold = thr;
        model_sweep(thr);
        tstep_start = 1'b1;
        @(negedge CK);
        tstep_start = 1'b0;
        wait_sweep(bp, rnd);
    endtask

    task automatic compare_spikes();
        check("spike_count", got_spk.size(), exp_spk.size());
        for (int i = 0; i < got_spk.size() && i < exp_spk.size(); i++)
            check("spike_addr", got_spk[i], exp_spk[i]);
    endtask

    task automatic compare_mem(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (sram[i] !== mdl[i]) begin
                checks++; errors++;
                $display("FAIL mem[%0d] actual=%0h expected=%0h", i, sram[i], mdl[i]);
            end else begin
                checks++;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        bit          pre;
        logic [31:0] init;
        int          wt;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        int lat;
        int n;
        vt[0] = '{8'd5,  1'b1, 32'hA500_0000,  100, 32'hA500_0064};
        vt[1] = '{8'd5,  1'b0, 32'h0,          -30, 32'hA500_0046};
        vt[2] = '{8'd9,  1'b1, 32'h0012_7FBC,  127, 32'h0012_7FFF};
        vt[3] = '{8'd10, 1'b1, 32'h0000_8008, -128, 32'h0000_8000};
        vt[4] = '{8'd11, 1'b1, 32'h3300_FFFF,    1, 32'h3300_0000};
        vt[5] = '{8'd12, 1'b1, 32'h0000_7FFF, -128, 32'h0000_7F7F};

        // Reset values while RST is asserted
        repeat (3) @(negedge CK);
        check("reset_ctrl", {evt_ready, busy, sweep_done, spike_valid, sram_cs, sram_we}, 0);
        check("reset_addr", {spike_addr, sram_a}, 0);
        check("reset_d", sram_d, 0);
        clear_all();
        RST = 1'b0;
        #1;
        check("ready_after_reset", evt_ready, 1);
        @(negedge CK);

        // Directed event vectors: integrate, chain, saturation both ways
        foreach (vt[i]) begin
            if (vt[i].pre) preload(vt[i].addr, vt[i].init);
            do_event(vt[i].addr, vt[i].wt, lat);
            check("vec_latency", lat, 3);
            check("vec_word", sram[vt[i].addr], vt[i].exp);
            mdl[vt[i].addr] = vt[i].exp;
        end

        // Sweep with single spike under 5 cycles of backpressure
        clear_all();
        preload(8'd3, 32'h5A00_0046);
        run_sweep(16'd50, 5, 1'b0);
        compare_spikes();
        check("spk_word3", sram[3], 32'h5A01_0000);
        compare_mem(0, 255);

        // Counter saturation
        clear_all();
        preload(8'd7, 32'h12FF_0064);
        run_sweep(16'd50, 0, 1'b0);
        compare_spikes();
        check("cnt_sat_word", sram[7], 32'h12FF_0000);

        // Leak behaviour (unchanged in the default build)
        clear_all();
        preload(8'd20, 32'h0000_00A0);
        preload(8'd21, 32'h0000_FFF0);
        run_sweep(16'd1000, 0, 1'b0);
        check("leak_pos", sram[20], c_leak ? 32'h0000_0096 : 32'h0000_00A0);
        check("leak_neg", sram[21], c_leak ? 32'h0000_FFF1 : 32'h0000_FFF0);
        check("leak_nospike", got_spk.size(), 0);

        // Reset mid-sweep at address 40
        clear_all();
        preload(8'd10, 32'h0000_0064);
        preload(8'd50, 32'h0000_0064);
        threshold = 16'd50;
        tstep_start = 1'b1;
        @(negedge CK);
        tstep_start = 1'b0;
        spike_ready = 1'b1;
        n = 0;
        while (!(sram_cs && !sram_we && sram_a == 8'd40) && n < 2000) begin
            @(negedge CK); n++;
        end
        check("reach_addr40", n < 2000, 1);
        RST = 1'b1;
        @(negedge CK);
        check("midrst_ctrl", {evt_ready, busy, sweep_done, spike_valid, sram_cs, sram_we}, 0);
        check("midrst_addr", {spike_addr, sram_a}, 0);
        check("midrst_d", sram_d, 0);
        RST = 1'b0;
        spike_ready = 1'b0;
        #1;
        check("midrst_ready", evt_ready, 1);
        @(negedge CK);
        check("midrst_untouched50", sram[50], 32'h0000_0064);
        check("midrst_done10", sram[10], 32'h0001_0000);
        mdl[10] = 32'h0001_0000;

        // Sweep request wins over a simultaneous event
        tstep_start = 1'b1; evt_valid = 1'b1; evt_addr = 8'd100; evt_weight = 8'd50;
        threshold = 16'd50;
        #1;
        check("prio_evt_ready", evt_ready, 0);
        model_sweep(16'd50);
        @(negedge CK);
        tstep_start = 1'b0; evt_valid = 1'b0;
        check("prio_sweep_rd", {busy, sram_cs, sram_we, sram_a}, {1'b1, 1'b1, 1'b0, 8'd0});
        wait_sweep(0, 1'b0);
        compare_spikes();
        compare_mem(0, 255);

        // Randomized events and sweeps against the reference model
        clear_all();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (i % 5 == 0) w[23:16] = 8'hFF;
            preload(i[7:0], w);
        end
        for (int it = 0; it < 6; it++) begin
            for (int e = 0; e < 12; e++) begin
                do_event(8'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128, lat);
                check("rnd_latency", lat, 3);
            end
            compare_mem(0, 15);
            run_sweep(16'(int'($urandom_range(0, 4000)) - 2000), 0, 1'b1);
            compare_spikes();
            compare_mem(0, 255);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
